// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl controller and its fill generator.
package mem_ctrl_pkg;
  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;
  localparam int WR_CYCLES  = 3;
  localparam int RD_CYCLES  = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_SETUP,
    S_W_PULSE,
    S_W_HOLD,
    S_R_SETUP,
    S_R_SAMPLE
  } mem_ctrl_state_t;
endpackage

// File: rtl/mem_fill_gen.sv
// Bulk-fill sequencer: walks addresses 0..DEPTH-1 and produces the (optionally
// alternating) fill pattern. The controller advances it once per W_HOLD.
module mem_fill_gen
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  input  logic              alt,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              last
);
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic              alt_q, alt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      pat_q <= '0;
      alt_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      pat_q <= pat_d;
      alt_q <= alt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    pat_d = pat_q;
    alt_d = alt_q;
    if (start) begin
      cnt_d = '0;
      pat_d = pattern;
      alt_d = alt;
    end else if (advance) begin
      cnt_d = cnt_q + 1'b1;
      if (alt_q) pat_d = ~pat_q;
    end
  end

  assign addr = cnt_q;
  assign data = pat_q;
  assign last = (cnt_q == {ADDR_W{1'b1}});
endmodule

// File: rtl/mem_ctrl.sv
// Valid/ready to async-SRAM pin-protocol controller (setup/pulse/hold writes,
// two-cycle reads). Optional bulk fill is built in with MEM_CTRL_FILL_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wdata_oe,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_CTRL_FILL_EN
  ,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_pattern,
  input  logic              fill_alt,
  output logic              fill_busy,
  output logic              fill_done
`endif
);
  mem_ctrl_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              write_q, write_d;
  logic              read_q, read_d;
  logic              oe_q, oe_d;
  logic              accept;
  logic              fill_go, fill_on, fill_last;

`ifdef MEM_CTRL_FILL_EN
  logic              fill_on_q, fill_on_d;
  logic              fill_done_q, fill_done_d;
  logic              fill_adv;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_data;

  assign fill_go  = (state_q == S_IDLE) && fill_start;
  assign fill_on  = fill_on_q;
  assign fill_adv = fill_on_q && (state_q == S_W_HOLD);

  mem_fill_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fill (
    .clk     (clk),
    .rst     (rst),
    .start   (fill_go),
    .pattern (fill_pattern),
    .alt     (fill_alt),
    .advance (fill_adv),
    .addr    (fill_addr),
    .data    (fill_data),
    .last    (fill_last)
  );

  always_comb begin
    fill_on_d   = fill_on_q;
    fill_done_d = fill_adv && fill_last;
    if (fill_go) fill_on_d = 1'b1;
    else if (fill_adv && fill_last) fill_on_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_on_q   <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      fill_on_q   <= fill_on_d;
      fill_done_q <= fill_done_d;
    end
  end

  assign fill_busy = fill_on_q;
  assign fill_done = fill_done_q;
  assign mem_addr  = fill_on_q ? fill_addr : addr_q;
  assign mem_wdata = fill_on_q ? fill_data : wdata_q;
`else
  assign fill_go   = 1'b0;
  assign fill_on   = 1'b0;
  assign fill_last = 1'b1;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`endif

  // Fill start wins over a simultaneous request, so hide ready in that cycle.
  assign req_ready = (state_q == S_IDLE) && !fill_go;
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      oe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      write_q     <= write_d;
      read_q      <= read_d;
      oe_q        <= oe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fill_go)     state_d = S_W_SETUP;
        else if (accept) state_d = req_we ? S_W_SETUP : S_R_SETUP;
      end
      S_W_SETUP:  state_d = S_W_PULSE;
      S_W_PULSE:  state_d = S_W_HOLD;
      S_W_HOLD:   state_d = (fill_on && !fill_last) ? S_W_SETUP : S_IDLE;
      S_R_SETUP:  state_d = S_R_SAMPLE;
      S_R_SAMPLE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state and registered so pins never glitch.
  always_comb begin
    write_d     = (state_d == S_W_PULSE);
    oe_d        = (state_d == S_W_SETUP) || (state_d == S_W_PULSE) || (state_d == S_W_HOLD);
    read_d      = (state_d == S_R_SETUP) || (state_d == S_R_SAMPLE);
    rsp_valid_d = !fill_on && ((state_q == S_W_HOLD) || (state_q == S_R_SAMPLE));
    rdata_d     = rdata_q;
    if (state_q == S_R_SAMPLE)           rdata_d = mem_rdata;
    else if (state_q == S_W_HOLD && !fill_on) rdata_d = '0;
    addr_d  = accept ? req_addr  : addr_q;
    wdata_d = accept ? req_wdata : wdata_q;
`ifdef MEM_CTRL_FILL_EN
    if (fill_adv && fill_last) begin
      addr_d  = fill_addr;
      wdata_d = fill_data;
    end
`endif
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rdata_q;
  assign mem_write    = write_q;
  assign mem_read     = read_q;
  assign mem_wdata_oe = oe_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural 32x8 array on the pin side.
module tb_mem_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid;
  logic [7:0] rsp_rdata;
  logic [4:0] mem_addr;
  logic       mem_read, mem_write, mem_wdata_oe;
  logic [7:0] mem_wdata, mem_rdata;
`ifdef MEM_CTRL_FILL_EN
  logic       fill_start = 1'b0, fill_alt = 1'b0;
  logic [7:0] fill_pattern = '0;
  logic       fill_busy, fill_done;
`endif

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
`ifdef MEM_CTRL_FILL_EN
    , .fill_start(fill_start), .fill_pattern(fill_pattern), .fill_alt(fill_alt),
    .fill_busy(fill_busy), .fill_done(fill_done)
`endif
  );

  logic [7:0] arr [32];
  always @(negedge clk) if (mem_write && mem_wdata_oe) arr[mem_addr] <= mem_wdata;
  assign mem_rdata = mem_read ? arr[mem_addr] : (mem_wdata_oe ? mem_wdata : 8'h00);

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("no_read_oe_overlap", mem_read && mem_wdata_oe, 0);
      chk("no_read_write_overlap", mem_read && mem_write, 0);
    end
  end

  // Entered at a negedge with the DUT in IDLE; returns at the negedge of the rsp cycle.
  task automatic do_txn(input logic we, input logic [4:0] a, input logic [7:0] d,
                        input logic chk_data, input logic [7:0] exp, output logic [7:0] got);
    int lat;
    lat = we ? 4 : 3;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    chk("req_ready", req_ready, 1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      chk("mem_write", mem_write, we && k == 2);
      chk("mem_wdata_oe", mem_wdata_oe, we && k < lat);
      chk("mem_read", mem_read, !we && k < lat);
      chk("rsp_valid", rsp_valid, k == lat);
      chk("mem_addr", mem_addr, a);
    end
    got = rsp_rdata;
    if (chk_data) chk("rsp_rdata", rsp_rdata, we ? 8'h00 : exp);
  endtask

  typedef struct {
    logic       we;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t vt [9];

  initial begin
    logic [7:0] got;
    for (int i = 0; i < 32; i++) arr[i] = 8'h00;
    vt[0] = '{1'b1, 5'h0A, 8'h5C, 8'h00};
    vt[1] = '{1'b0, 5'h0A, 8'h00, 8'h5C};
    vt[2] = '{1'b1, 5'h1F, 8'hAA, 8'h00};
    vt[3] = '{1'b1, 5'h00, 8'h55, 8'h00};
    vt[4] = '{1'b0, 5'h1F, 8'h00, 8'hAA};
    vt[5] = '{1'b0, 5'h00, 8'h00, 8'h55};
    vt[6] = '{1'b0, 5'h0A, 8'h00, 8'h5C};
    vt[7] = '{1'b1, 5'h0A, 8'h33, 8'h00};
    vt[8] = '{1'b0, 5'h0A, 8'h00, 8'h33};

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_strobes", {mem_read, mem_write, mem_wdata_oe}, 0);
`ifdef MEM_CTRL_FILL_EN
    chk("rst_fill", {fill_busy, fill_done}, 0);
`endif
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      do_txn(vt[i].we, vt[i].addr, vt[i].wdata, 1'b1, vt[i].exp, got);
      // rsp cycle of a read is also the bus-turnaround cycle before a following write
      chk("turnaround", {mem_read, mem_wdata_oe}, 0);
    end

    // Reset during W_PULSE of a write to 0x03
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h03; req_wdata = 8'h77;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_pulse", mem_write, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_strobes", {mem_read, mem_write, mem_wdata_oe}, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_req_ready", req_ready, 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", rsp_valid, 0);
    end
    do_txn(1'b0, 5'h03, 8'h00, 1'b0, 8'h00, got);
    chk("abort_read_known", !$isunknown(got) && (got == 8'h00 || got == 8'h77), 1);

`ifdef MEM_CTRL_FILL_EN
    begin
      int  busy;
      bit  done;
      busy = 0; done = 1'b0;
      fill_start = 1'b1; fill_pattern = 8'hAA; fill_alt = 1'b1;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h05;
      chk("fill_prio_ready", req_ready, 0);
      for (int c = 0; c < 300 && !done; c++) begin
        @(negedge clk);
        if (c == 0) fill_start = 1'b0;
        if (fill_busy) busy++;
        if (fill_done) done = 1'b1;
        chk("fill_no_rsp", rsp_valid, 0);
      end
      chk("fill_done_seen", done, 1);
      chk("fill_busy_cycles", busy, 96);
      chk("fill_done_ready", req_ready, 1);
      for (int a = 5; a <= 9; a++)
        do_txn(1'b0, 5'(a), 8'h00, 1'b1, a[0] ? 8'h55 : 8'hAA, got);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
